// File: rtl/lfa14_multiword_adder.sv
// Word-serial WORDS*14-bit adder: one Ladner-Fischer 14-bit core, carry chained LSW->MSW via carry_q.
// Optional LFA14_SIGNED_OVF_EN adds out_ovf (two's-complement overflow on the MSW).

module lfa14_core (
   input  logic [13:0] a_i,
   input  logic [13:0] b_i,
   input  logic        cin_i,
   output logic [14:0] sum_o
);
   // Sparse prefix tree: at level l, bit i (with bit l of i set) merges the group ending just below its 2^l block.
   function automatic logic [14:0] lf_add(input logic [13:0] a, input logic [13:0] b, input logic cin);
      logic [13:0] g, p, gn, pn, hp;
      logic [14:0] c;
      int j;
      hp = a ^ b;
      g  = a & b;
      g[0] = g[0] | (hp[0] & cin);
      p  = hp;
      for (int l = 0; l < 4; l++) begin
         gn = g;
         pn = p;
         for (int i = 0; i < 14; i++) begin
            if (((i >> l) & 1) == 1) begin
               j = ((i >> l) << l) - 1;
               gn[i] = g[i] | (p[i] & g[j]);
               pn[i] = p[i] & p[j];
            end
         end
         g = gn;
         p = pn;
      end
      c[0]    = cin;
      c[14:1] = g;
      return {c[14], hp ^ c[13:0]};
   endfunction

   assign sum_o = lf_add(a_i, b_i, cin_i);
endmodule

module lfa14_multiword_adder #(
   parameter int WORDS = 4,
   parameter int CNT_W = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [13:0] in_x,
   input  logic [13:0] in_y,
   input  logic        in_first,
   input  logic        in_last,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [13:0] out_s,
   output logic        out_last,
   output logic        out_carry,
   output logic        err
`ifdef LFA14_SIGNED_OVF_EN
   ,
   output logic        out_ovf
`endif
);
   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] word_cnt_q, word_cnt_d, idx;
   logic             carry_q, carry_d;
   logic             out_valid_q, out_valid_d;
   logic [13:0]      out_s_q, out_s_d;
   logic             out_last_q, out_last_d;
   logic             out_carry_q, out_carry_d;
   logic             err_q, err_d;
   logic             accept, cin, restart;
   logic [14:0]      sum;
`ifdef LFA14_SIGNED_OVF_EN
   logic             out_ovf_q, out_ovf_d;
`endif

   assign in_ready = !out_valid_q | out_ready;
   assign accept   = in_valid & in_ready;
   // A word starts a new operand (index 0, cin 0) from IDLE or on any in_first.
   assign restart  = (state_q == IDLE) | in_first;
   assign idx      = restart ? '0 : word_cnt_q;
   assign cin      = restart ? 1'b0 : carry_q;

   lfa14_core u_core (
      .a_i   (in_x),
      .b_i   (in_y),
      .cin_i (cin),
      .sum_o (sum)
   );

   always_comb begin
      state_d     = state_q;
      word_cnt_d  = word_cnt_q;
      carry_d     = carry_q;
      out_valid_d = out_valid_q & !out_ready;
      out_s_d     = out_s_q;
      out_last_d  = out_last_q;
      out_carry_d = out_carry_q;
      err_d       = err_q;
`ifdef LFA14_SIGNED_OVF_EN
      out_ovf_d   = out_ovf_q;
`endif
      if (accept) begin
         out_valid_d = 1'b1;
         out_s_d     = sum[13:0];
         out_last_d  = in_last;
         out_carry_d = sum[14] & in_last;
         carry_d     = sum[14];
`ifdef LFA14_SIGNED_OVF_EN
         out_ovf_d   = in_last & (in_x[13] == in_y[13]) & (sum[13] != in_x[13]);
`endif
         if (((state_q == IDLE) & !in_first) | ((state_q == BUSY) & in_first) |
             (in_last & (idx != LAST_IDX)) | (!in_last & (idx == LAST_IDX)))
            err_d = 1'b1;
         if (in_last | (idx == LAST_IDX)) begin
            state_d    = IDLE;
            word_cnt_d = '0;
         end else begin
            state_d    = BUSY;
            word_cnt_d = idx + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         word_cnt_q  <= '0;
         carry_q     <= 1'b0;
         out_valid_q <= 1'b0;
         out_s_q     <= '0;
         out_last_q  <= 1'b0;
         out_carry_q <= 1'b0;
         err_q       <= 1'b0;
`ifdef LFA14_SIGNED_OVF_EN
         out_ovf_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         word_cnt_q  <= word_cnt_d;
         carry_q     <= carry_d;
         out_valid_q <= out_valid_d;
         out_s_q     <= out_s_d;
         out_last_q  <= out_last_d;
         out_carry_q <= out_carry_d;
         err_q       <= err_d;
`ifdef LFA14_SIGNED_OVF_EN
         out_ovf_q   <= out_ovf_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign out_s     = out_s_q;
   assign out_last  = out_last_q;
   assign out_carry = out_carry_q;
   assign err       = err_q;
`ifdef LFA14_SIGNED_OVF_EN
   assign out_ovf   = out_ovf_q;
`endif
endmodule

// File: doc/lfa14_multiword_adder.md
Name: lfa14_multiword_adder

Overview:
- Sequential multi-word adder that streams WORDS-word operands, least-significant word first, through one 14-bit Ladner-Fischer carry-in adder core (14+14+Cin -> 15-bit sum).
- Per-word carry is registered and chained into the next word, so wide additions reuse the single combinational adder.
- Sits between the operand-source stream and the result consumer; valid/ready handshake on both sides.

Parameters:
- WORDS, 4, number of 14-bit words per operand (total width WORDS*14); legal range 2..16.
- CNT_W, 4, width of the word counter; must satisfy 2**CNT_W >= WORDS.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  input word present.
- in_ready  output  1  block accepts the input word this cycle.
- in_x  input  14  operand X word.
- in_y  input  14  operand Y word.
- in_first  input  1  word is the LSW of a new operand pair.
- in_last  input  1  word is the MSW.
- out_valid  output  1  result word held.
- out_ready  input  1  consumer accepts the result word.
- out_s  output  14  sum word.
- out_last  output  1  sum word is the MSW.
- out_carry  output  1  final carry-out; meaningful only when out_last=1, otherwise 0.
- err  output  1  sticky framing error.

Behaviour:
- Handshake: input accepted when in_valid & in_ready; output transfers when out_valid & out_ready; in_ready = !out_valid | out_ready (single output register, no combinational path from in_valid to out_valid).
- Per accepted word: {c, s} = in_x + in_y + cin, with cin = 0 if in_first, else carry_q. s registers into out_s and c into carry_q. The adder core is instantiated with its carry-in port driven, not tied to zero.
- Latency: 1 cycle from acceptance to out_valid. Throughput: 1 word/cycle while out_ready=1.
- out_last <= in_last. out_carry <= c & in_last.
- FSM:
  - IDLE: expects in_first. An accepted word with in_first=0 sets err, is still summed with cin=0, and moves to BUSY.
  - BUSY: word_cnt increments on each accepted word.
  - An accepted in_last returns the FSM to IDLE. If word_cnt != WORDS-1 at that point, err is set.
  - In BUSY, if word_cnt reaches WORDS-1 without in_last, err is set and the FSM returns to IDLE (the counter wraps to 0).
  - An in_first accepted while in BUSY sets err and restarts: cin=0, word_cnt=0.
- A word flagged both in_first and in_last is a legal single word only when WORDS=1. Since WORDS>=2 forbids this, the combination sets err and is processed as a one-word operand.
- Backpressure: while out_valid & !out_ready, all registers hold and in_ready=0.
- Reset: mid-operation reset drops any partial operand without emitting it. Reset values: out_valid=0, out_s=0, out_last=0, out_carry=0, err=0, carry_q=0, word_cnt=0, state=IDLE. err clears only on reset.

Optional Feature:
- Macro: LFA14_SIGNED_OVF_EN.
- Defined:
  - Adds output port out_ovf (1 bit, reset 0).
  - On the MSW, out_ovf <= (in_x[13] == in_y[13]) & (s[13] != in_x[13]), i.e. two's-complement overflow of the full WORDS*14-bit sum.
  - out_ovf is 0 on non-last words and holds with the output register under backpressure.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan (all with WORDS=4):
- Carry ripple across words: operands X=0x3FFF,0x3FFF,0x3FFF,0x0000 and Y=0x0001,0,0,0 (LSW first), out_ready=1. Required: out_s=0x0000,0x0000,0x0000,0x0001; out_last only on the 4th word; out_carry=0; err=0; out_valid 1 cycle after each acceptance.
- Final carry-out: all X words 0x3FFF, Y=0x0001,0,0,0. Required: out_s=0,0,0,0; out_carry=1 on the last word.
- Backpressure: hold out_ready=0 for 3 cycles after the first word. Required: in_ready=0, out_s held at the first result; no words lost or duplicated; sequence completes correctly after release.
- Framing error: in_last on the 2nd word. Required: err=1 from the cycle after acceptance and sticky. The next operand starting with in_first sums correctly with cin=0.
- Reset mid-operand: rst after 2 words, then a full legal operand 0x0001 + 0x0002 in the LSW with other words 0. Required: all outputs 0 during reset; result words 0x0003,0,0,0; err=0.
- With LFA14_SIGNED_OVF_EN: MSW X=0x1FFF, Y=0x0001, lower words 0. Required: out_s MSW=0x2000, out_ovf=1, out_carry=0.
